// File: rtl/fdiv_sched.sv
// fdiv_sched: schedules two requesters onto one shared fixed-latency FP32 divider.
//
// Ports:
//   clk, rst_n             single rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready    per-port request handshake (bit i = port i), round-robin arbitration
//   req_a/req_b            operand pairs, [31:0] port 0, [63:32] port 1
//   dv_a/dv_b              registered operands driven to the divider
//   dv_sign/exp/frac/flags divider result, sampled LATENCY cycles after accept
//   rsp_valid/rsp_ready    response handshake; rsp_id/rsp_data/rsp_flags held while stalled
//   busy                   high whenever an operation is in flight or awaiting handshake
//   err_cnt                saturating count of flagged responses
//
// Build option: define FDIV_SCHED_ERR_CNT_EN to enable the err_cnt counter; otherwise err_cnt
// is tied to 0 and no counter flops exist.
module fdiv_sched #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] dv_a,
  output logic [31:0] dv_b,
  input  logic        dv_sign,
  input  logic [7:0]  dv_exp,
  input  logic [23:0] dv_frac,
  input  logic [1:0]  dv_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_flags,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic [31:0] dv_a_q, dv_a_d;
  logic [31:0] dv_b_q, dv_b_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_flags_q, rsp_flags_d;
  logic [1:0]  grant;
  logic        accept;

  // The hidden-bit position of the divider fraction is not forwarded.
  logic unused_frac_msb;
  assign unused_frac_msb = dv_frac[23];

  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign accept = (state_q == StIdle) && (|req_valid);

  // Gated by rst_n so req_ready is 0 while reset is held, even with requests pending.
  assign req_ready = (state_q == StIdle && rst_n) ? grant : 2'b00;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    dv_a_d      = dv_a_q;
    dv_b_d      = dv_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          prio_d  = grant[0];  // pointer moves to the port not just granted
          id_d    = grant[1];
          dv_a_d  = grant[1] ? req_a[63:32] : req_a[31:0];
          dv_b_d  = grant[1] ? req_b[63:32] : req_b[31:0];
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d     = StResp;
          rsp_data_d  = {dv_sign, dv_exp, dv_frac[22:0]};
          rsp_flags_d = dv_flags;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      cnt_q       <= 4'd0;
      id_q        <= 1'b0;
      dv_a_q      <= 32'd0;
      dv_b_q      <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_flags_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      dv_a_q      <= dv_a_d;
      dv_b_q      <= dv_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign dv_a      = dv_a_q;
  assign dv_b      = dv_b_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (state_q != StIdle);

`ifdef FDIV_SCHED_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == StResp && rsp_ready && (|rsp_flags_q) && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fdiv_sched.sv
// tb_fdiv_sched: directed bench for fdiv_sched with an operation-level reference model and a
// bench-side divider that only presents a correct result in the cycle before the capture edge.
module tb_fdiv_sched;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [31:0] dv_a, dv_b;
  logic        dv_sign;
  logic [7:0]  dv_exp;
  logic [23:0] dv_frac;
  logic [1:0]  dv_flags;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_flags;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  fdiv_sched #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .dv_a(dv_a), .dv_b(dv_b), .dv_sign(dv_sign),
    .dv_exp(dv_exp), .dv_frac(dv_frac), .dv_flags(dv_flags), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .busy(busy), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Divider behaviour: {flags, sign, exp, frac[22:0]}.
  function automatic logic [33:0] div_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return {2'b00, 32'h4040_0000};
    if (b[30:0] == 31'd0 || a[30:23] == 8'hFF) return {2'b10, a[31] ^ b[31], 8'hFF, 23'h40_0000};
    return {2'b00, a ^ {b[7:0], b[31:8]}};
  endfunction

  function automatic int grant_idx(input logic [1:0] v, input bit ptr);
    if (v == 2'b11) return int'(ptr);
    return int'(v[1]);
  endfunction

  // Reference model: phase 0 idle, 1 dividing, 2 holding a response.
  int          m_phase, m_elapsed, m_err;
  bit          m_ptr, m_owner;
  logic [31:0] m_a, m_b, m_data;
  logic [1:0]  m_flags;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_elapsed <= 0; m_err <= 0; m_ptr <= 1'b0; m_owner <= 1'b0;
      m_a <= '0; m_b <= '0; m_data <= '0; m_flags <= '0;
    end else if (m_phase == 0) begin
      if (|req_valid) begin
        m_owner   <= bit'(grant_idx(req_valid, m_ptr));
        m_ptr     <= ~bit'(grant_idx(req_valid, m_ptr));
        m_a       <= req_a[grant_idx(req_valid, m_ptr)*32 +: 32];
        m_b       <= req_b[grant_idx(req_valid, m_ptr)*32 +: 32];
        m_phase   <= 1;
        m_elapsed <= 0;
      end
    end else if (m_phase == 1) begin
      m_elapsed <= m_elapsed + 1;
      if (m_elapsed + 1 == LAT) begin
        {m_flags, m_data} <= div_fn(m_a, m_b);
        m_phase <= 2;
      end
    end else if (rsp_ready) begin
`ifdef FDIV_SCHED_ERR_CNT_EN
      if (m_flags != 2'b00 && m_err < 255) m_err <= m_err + 1;
`endif
      m_phase <= 0;
    end
  end

  // Shared divider: valid only in the cycle preceding the capture edge, junk otherwise.
  logic [22:0] dv_frac23;
  always_comb begin
    {dv_flags, dv_sign, dv_exp, dv_frac23} = {2'b01, 1'b1, 8'hEE, 23'h5A_5A5A};
    if (m_phase == 1 && m_elapsed == LAT - 1) {dv_flags, dv_sign, dv_exp, dv_frac23} = div_fn(dv_a, dv_b);
    dv_frac = {1'b1, dv_frac23};
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [1:0] exp_ready;
    exp_ready = (rst_n && m_phase == 0 && |req_valid) ?
                (2'b01 << grant_idx(req_valid, m_ptr)) : 2'b00;
    check("req_ready", req_ready, exp_ready);
    check("dv_a", dv_a, m_a);
    check("dv_b", dv_b, m_b);
    check("busy", busy, rst_n && m_phase != 0);
    check("rsp_valid", rsp_valid, rst_n && m_phase == 2);
    check("err_cnt", err_cnt, m_err[7:0]);
    if (m_phase == 2 || !rst_n) begin
      check("rsp_id", rsp_id, m_owner);
      check("rsp_data", rsp_data, m_data);
      check("rsp_flags", rsp_flags, m_flags);
    end
  end

  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b);
    req_a[port*32 +: 32] = a;
    req_b[port*32 +: 32] = b;
    req_valid[port] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[port]) begin
        @(posedge clk); #1;
        req_valid[port] = 1'b0;
        return;
      end
    end
    req_valid[port] = 1'b0;
    timeout("issue");
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) return;
    end
    timeout("wait_resp");
  endtask

  int         cyc;
  logic [1:0] grants [3];
  int         ng;
  logic [33:0] exp_r;

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    req_a = {32'h4100_0000, 32'h4080_0000}; req_b = {2{32'h4000_0000}};
    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    req_valid = 2'b00; rst_n = 1'b1;

    // 6.0 / 2.0 on port 0.
    rsp_ready = 1'b1;
    issue(0, 32'h40C0_0000, 32'h4000_0000);
    wait_resp(cyc);
    check("latency", cyc - 1, LAT);
    check("six_by_two_data", rsp_data, 32'h4040_0000);
    check("six_by_two_id", rsp_id, 1'b0);
    check("six_by_two_flags", rsp_flags, 2'b00);
    @(posedge clk); #1;

    // Reset in the middle of an operation; pointer currently favours port 1.
    issue(0, 32'h3F80_0000, 32'h4000_0000);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = {32'h4100_0000, 32'h4080_0000}; req_b = {2{32'h4000_0000}};
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_dv_a", dv_a, 32'd0);
    check("abort_req_ready", req_ready, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both ports requesting continuously: 0, 1, 0.
    ng = 0;
    for (int i = 0; i < 200 && ng < 3; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        grants[ng] = req_ready;
        ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (ng < 3) timeout("round_robin");
    else begin
      check("rr_grant0", grants[0], 2'b01);
      check("rr_grant1", grants[1], 2'b10);
      check("rr_grant2", grants[2], 2'b01);
    end
    wait_resp(cyc);
    @(posedge clk); #1;

    // Backpressure: response held for 10 cycles while port 0 waits.
    rsp_ready = 1'b0;
    issue(1, 32'h4120_0000, 32'h40A0_0000);
    wait_resp(cyc);
    req_a[31:0] = 32'h4110_0000; req_b[31:0] = 32'h3F00_0000; req_valid[0] = 1'b1;
    exp_r = div_fn(32'h4120_0000, 32'h40A0_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data", rsp_data, exp_r[31:0]);
      check("stall_id", rsp_id, 1'b1);
      check("stall_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("accept_after_handshake", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_resp(cyc);
    @(posedge clk); #1;

    // 0/0 on port 1, then saturate the error counter.
    issue(1, 32'h0000_0000, 32'h0000_0000);
    wait_resp(cyc);
    check("zero_by_zero_flags", rsp_flags, 2'b10);
    check("zero_by_zero_id", rsp_id, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
`ifdef FDIV_SCHED_ERR_CNT_EN
    check("err_cnt_first", err_cnt, 8'd1);
`else
    check("err_cnt_first", err_cnt, 8'd0);
`endif
    for (int i = 0; i < 299; i++) begin
      issue(0, 32'h3F80_0000, 32'h0000_0000);
      wait_resp(cyc);
      @(posedge clk); #1;
    end
    @(negedge clk);
`ifdef FDIV_SCHED_ERR_CNT_EN
    check("err_cnt_saturated", err_cnt, 8'd255);
`else
    check("err_cnt_saturated", err_cnt, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
